// File: rtl/mem_access.sv
// mem_access: MEM stage; byte-serial loads/stores over a byte-wide RAM, registered MEM/WB bundle.
// Build option MEM_ALIGN_CHECK_EN squashes misaligned H/W accesses and pulses misalign_o.
//
// Ports:
//   clk, rst                 clock (rising edge), asynchronous active-high reset
//   *_EXMEM_i                EX/MEM bundle: aluop, wreg, waddr, alurslt (address), storedata
//   mem_din_i                RAM read byte, valid one cycle after its address
//   mem_addr_o/dout_o/wr_o   RAM byte address, write byte, write strobe
//   stall_req_o              holds IF..EX/MEM while an access is in flight
//   *_MEMWB_o                registered writeback bundle
//   misalign_o               one-cycle squash pulse (MEM_ALIGN_CHECK_EN builds only)

package mem_access_pkg;
    localparam int ALU_OP_W = 6;
    typedef logic [ALU_OP_W-1:0] AluOpBus;

    localparam AluOpBus ALU_NOP_OP = 6'h00;
    localparam AluOpBus ALU_ADD_OP = 6'h01;
    localparam AluOpBus ALU_LB_OP  = 6'h10;
    localparam AluOpBus ALU_LH_OP  = 6'h11;
    localparam AluOpBus ALU_LW_OP  = 6'h12;
    localparam AluOpBus ALU_LBU_OP = 6'h13;
    localparam AluOpBus ALU_LHU_OP = 6'h14;
    localparam AluOpBus ALU_SB_OP  = 6'h18;
    localparam AluOpBus ALU_SH_OP  = 6'h19;
    localparam AluOpBus ALU_SW_OP  = 6'h1A;
endpackage

module mem_access
    import mem_access_pkg::*;
#(
    parameter int ADDR_W = 17
) (
    input  logic              clk,
    input  logic              rst,
    input  AluOpBus           aluop_EXMEM_i,
    input  logic              wreg_EXMEM_i,
    input  logic [4:0]        waddr_EXMEM_i,
    input  logic [31:0]       alurslt_EXMEM_i,
    input  logic [31:0]       storedata_EXMEM_i,
    input  logic [7:0]        mem_din_i,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [7:0]        mem_dout_o,
    output logic              mem_wr_o,
    output logic              stall_req_o,
    output logic              wreg_MEMWB_o,
    output logic [4:0]        waddr_MEMWB_o,
    output logic [31:0]       wdata_MEMWB_o,
    output logic              misalign_o
);

    typedef enum logic [1:0] {IDLE, XFER, TAIL, FINISH} state_t;

    function automatic logic is_load_f(input AluOpBus op);
        is_load_f = (op == ALU_LB_OP) || (op == ALU_LH_OP) || (op == ALU_LW_OP) ||
                    (op == ALU_LBU_OP) || (op == ALU_LHU_OP);
    endfunction

    function automatic logic is_store_f(input AluOpBus op);
        is_store_f = (op == ALU_SB_OP) || (op == ALU_SH_OP) || (op == ALU_SW_OP);
    endfunction

    function automatic logic [2:0] nbytes_f(input AluOpBus op);
        case (op)
            ALU_LH_OP, ALU_LHU_OP, ALU_SH_OP: nbytes_f = 3'd2;
            ALU_LW_OP, ALU_SW_OP:             nbytes_f = 3'd4;
            default:                          nbytes_f = 3'd1;
        endcase
    endfunction

    state_t            state_q, state_d;
    logic [1:0]        cnt_q, cnt_d;
    AluOpBus           op_q;
    logic [ADDR_W-1:0] base_q;
    logic [31:0]       sdata_q;
    logic              wreg_q;
    logic [4:0]        waddr_q;
    logic [23:0]       ldata_q, ldata_d;
    logic              memwb_wreg_q, memwb_wreg_d;
    logic [4:0]        memwb_waddr_q, memwb_waddr_d;
    logic [31:0]       memwb_wdata_q, memwb_wdata_d;

    logic       in_mem;
    logic [2:0] in_nb;
    logic       in_misal;
    logic       accept;
    logic       load_q;
    logic       store_q;
    logic [2:0] nb_q;
    logic       last;
    logic [31:0] raw;
    logic [31:0] ext;
    logic [31:0] sshift;

    assign in_mem = is_load_f(aluop_EXMEM_i) || is_store_f(aluop_EXMEM_i);
    assign in_nb  = nbytes_f(aluop_EXMEM_i);

`ifdef MEM_ALIGN_CHECK_EN
    assign in_misal = in_mem &&
                      (((in_nb == 3'd2) && alurslt_EXMEM_i[0]) ||
                       ((in_nb == 3'd4) && (alurslt_EXMEM_i[1:0] != 2'b00)));
`else
    assign in_misal = 1'b0;
`endif

    assign accept  = (state_q == IDLE) && in_mem && !in_misal;
    assign load_q  = is_load_f(op_q);
    assign store_q = is_store_f(op_q);
    assign nb_q    = nbytes_f(op_q);
    assign last    = ({1'b0, cnt_q} == (nb_q - 3'd1));

    // state register and latched operation
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            cnt_q         <= 2'd0;
            op_q          <= ALU_NOP_OP;
            base_q        <= '0;
            sdata_q       <= 32'd0;
            wreg_q        <= 1'b0;
            waddr_q       <= 5'd0;
            ldata_q       <= 24'd0;
            memwb_wreg_q  <= 1'b0;
            memwb_waddr_q <= 5'd0;
            memwb_wdata_q <= 32'd0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            ldata_q       <= ldata_d;
            memwb_wreg_q  <= memwb_wreg_d;
            memwb_waddr_q <= memwb_waddr_d;
            memwb_wdata_q <= memwb_wdata_d;
            if (accept) begin
                op_q    <= aluop_EXMEM_i;
                base_q  <= alurslt_EXMEM_i[ADDR_W-1:0];
                sdata_q <= storedata_EXMEM_i;
                wreg_q  <= wreg_EXMEM_i;
                waddr_q <= waddr_EXMEM_i;
            end
        end
    end

    // next state
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                cnt_d = 2'd0;
                if (accept) state_d = XFER;
            end
            XFER: begin
                cnt_d = cnt_q + 2'd1;
                if (last) state_d = load_q ? TAIL : FINISH;
            end
            TAIL:    state_d = FINISH;
            FINISH:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Read data trails its address by one cycle, so byte k lands while cnt=k+1,
    // and the last byte arrives in TAIL.
    always_comb begin
        ldata_d = ldata_q;
        if ((state_q == XFER) && load_q) begin
            case (cnt_q)
                2'd1:    ldata_d[7:0]   = mem_din_i;
                2'd2:    ldata_d[15:8]  = mem_din_i;
                2'd3:    ldata_d[23:16] = mem_din_i;
                default: ldata_d = ldata_q;
            endcase
        end
    end

    always_comb begin
        case (nb_q)
            3'd1:    raw = {24'd0, mem_din_i};
            3'd2:    raw = {16'd0, mem_din_i, ldata_q[7:0]};
            default: raw = {mem_din_i, ldata_q};
        endcase
        case (op_q)
            ALU_LB_OP:  ext = {{24{raw[7]}}, raw[7:0]};
            ALU_LH_OP:  ext = {{16{raw[15]}}, raw[15:0]};
            ALU_LBU_OP: ext = {24'd0, raw[7:0]};
            ALU_LHU_OP: ext = {16'd0, raw[15:0]};
            default:    ext = raw;
        endcase
    end

    // MEM/WB next value: bubble unless passing a non-mem op or finishing a load
    always_comb begin
        memwb_wreg_d  = 1'b0;
        memwb_waddr_d = 5'd0;
        memwb_wdata_d = 32'd0;
        if ((state_q == IDLE) && !in_mem) begin
            memwb_wreg_d  = wreg_EXMEM_i;
            memwb_waddr_d = waddr_EXMEM_i;
            memwb_wdata_d = alurslt_EXMEM_i;
        end else if (state_q == TAIL) begin
            memwb_wreg_d  = wreg_q;
            memwb_waddr_d = waddr_q;
            memwb_wdata_d = ext;
        end
    end

    assign sshift = sdata_q >> {cnt_q, 3'b000};

    // outputs; stall and misalign are gated by rst so they drop with it
    always_comb begin
        mem_addr_o  = '0;
        mem_dout_o  = 8'd0;
        mem_wr_o    = 1'b0;
        stall_req_o = 1'b0;
        misalign_o  = 1'b0;
        unique case (state_q)
            IDLE: begin
                stall_req_o = !rst && accept;
                misalign_o  = !rst && in_misal;
            end
            XFER: begin
                stall_req_o = !rst;
                mem_addr_o  = base_q + {{(ADDR_W-2){1'b0}}, cnt_q};
                mem_wr_o    = store_q;
                mem_dout_o  = store_q ? sshift[7:0] : 8'd0;
            end
            TAIL:    stall_req_o = !rst;
            FINISH:  stall_req_o = 1'b0;
            default: stall_req_o = 1'b0;
        endcase
    end

    assign wreg_MEMWB_o  = memwb_wreg_q;
    assign waddr_MEMWB_o = memwb_waddr_q;
    assign wdata_MEMWB_o = memwb_wdata_q;

endmodule
